// File: rtl/rv32i_alu_pkg.sv
// rv32i_alu_pkg: op encodings, shifter FSM states and op-class helpers for rv32i_alu_pipe.
package rv32i_alu_pkg;
  localparam int ALU_OP_W = 4;
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NE   = 4'd11,
    ALU_GE   = 4'd12,
    ALU_GEU  = 4'd13
  } alu_op_e;
  typedef enum logic {SH_IDLE, SH_SHIFT} sh_state_e;
  function automatic logic op_is_shift(alu_op_e op);
    return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction
  function automatic logic op_is_cmp(alu_op_e op);
    return op inside {ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_GE, ALU_GEU};
  endfunction
endpackage

// File: rtl/rv32i_alu_serial_shifter.sv
// rv32i_alu_serial_shifter: iterative shifter moving up to SHIFT_STEP bits per cycle.
module rv32i_alu_serial_shifter import rv32i_alu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int TAG_W = 37,
  parameter int SHIFT_STEP = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    flush,
  input  logic                    stall,
  input  alu_op_e                 ld_op,
  input  logic [XLEN-1:0]         ld_a,
  input  logic [$clog2(XLEN)-1:0] ld_shamt,
  input  logic                    ld_wr_rd,
  input  logic [TAG_W-1:0]        ld_tag,
  output logic                    busy,
  output logic                    done,
  output logic [XLEN-1:0]         y,
  output logic                    wr_rd,
  output logic [TAG_W-1:0]        tag
);
  localparam int SW = $clog2(XLEN);
  localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);
  sh_state_e state, state_d;
  alu_op_e op_q;
  logic [XLEN-1:0] r, r_d, sra;
  logic [SW:0] rem, rem_d, step, nrem;
  logic load;
  assign step = rem < STEP ? rem : STEP;
  assign nrem = rem - step;
  assign sra = $signed(r) >>> step;
  assign y = op_q == ALU_SLL ? r << step : op_q == ALU_SRL ? r >> step : sra;
  assign busy = state == SH_SHIFT;
  // The final step's result is handed out combinationally so the op enters stage 0 that same edge.
  always_comb begin
    state_d = state;
    r_d = r;
    rem_d = rem;
    load = 1'b0;
    done = 1'b0;
    if (flush) state_d = SH_IDLE;
    else if (state == SH_IDLE) begin
      if (start) begin
        state_d = SH_SHIFT;
        r_d = ld_a;
        rem_d = {1'b0, ld_shamt};
        load = 1'b1;
      end
    end else if (nrem != '0) begin
      r_d = y;
      rem_d = nrem;
    end else if (!stall) begin
      done = 1'b1;
      state_d = SH_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= SH_IDLE;
      r <= '0;
      rem <= '0;
      op_q <= ALU_ADD;
      wr_rd <= 1'b0;
      tag <= '0;
    end else begin
      state <= state_d;
      r <= r_d;
      rem <= rem_d;
      if (load) begin
        op_q <= ld_op;
        wr_rd <= ld_wr_rd;
        tag <= ld_tag;
      end
    end
endmodule

// File: rtl/rv32i_alu_pipe.sv
// rv32i_alu_pipe: parametrised pipelined execute ALU with stall/flush handshake.
// Define ALU_SERIAL_SHIFT_EN to replace the barrel shifter with the iterative shifter.
module rv32i_alu_pipe import rv32i_alu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int STAGES = 2,
  parameter int TAG_W = 37,
  parameter int SHIFT_STEP = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ce,
  input  logic [ALU_OP_W-1:0] i_op,
  input  logic [XLEN-1:0]     i_a,
  input  logic [XLEN-1:0]     i_b,
  input  logic                i_wr_rd,
  input  logic [TAG_W-1:0]    i_tag,
  input  logic                i_stall,
  input  logic                i_flush,
  output logic                o_ce,
  output logic [XLEN-1:0]     o_y,
  output logic                o_wr_rd,
  output logic [TAG_W-1:0]    o_tag,
  output logic                o_stall,
  output logic                o_flush
);
  localparam int SW = $clog2(XLEN);
  if (!(XLEN == 32 || XLEN == 64) || STAGES < 1 || SHIFT_STEP < 1 || SHIFT_STEP > XLEN ||
      (SHIFT_STEP & (SHIFT_STEP - 1)) != 0) begin : g_bad_cfg
    $error("rv32i_alu_pipe: unsupported parameter set");
  end
  alu_op_e op;
  logic [SW-1:0] shamt;
  logic [XLEN-1:0] sh_y, y_comb, y0;
  logic [TAG_W-1:0] tag0;
  logic busy, accept, cmp, v0, wr0;
  assign op = alu_op_e'(i_op);
  assign shamt = i_b[SW-1:0];
  assign o_stall = i_stall | busy;
  assign accept = i_ce & ~o_stall;
  assign cmp = op == ALU_SLT  ? $signed(i_a) < $signed(i_b) :
               op == ALU_SLTU ? i_a < i_b :
               op == ALU_EQ   ? i_a == i_b :
               op == ALU_NE   ? i_a != i_b :
               op == ALU_GE   ? $signed(i_a) >= $signed(i_b) : i_a >= i_b;
  assign y_comb = op_is_cmp(op)   ? XLEN'(cmp) :
                  op_is_shift(op) ? sh_y :
                  op == ALU_ADD   ? i_a + i_b :
                  op == ALU_SUB   ? i_a - i_b :
                  op == ALU_AND   ? i_a & i_b :
                  op == ALU_OR    ? i_a | i_b :
                  op == ALU_XOR   ? i_a ^ i_b : '0;
`ifdef ALU_SERIAL_SHIFT_EN
  logic start, done, s_wr;
  logic [XLEN-1:0] s_y;
  logic [TAG_W-1:0] s_tag;
  // Zero-distance shifts bypass the FSM and simply pass operand A.
  assign start = accept & op_is_shift(op) & (|shamt);
  assign sh_y = i_a;
  rv32i_alu_serial_shifter #(.XLEN(XLEN), .TAG_W(TAG_W), .SHIFT_STEP(SHIFT_STEP)) u_shift (
    .clk(i_clk), .rst(i_rst), .start(start), .flush(i_flush), .stall(i_stall),
    .ld_op(op), .ld_a(i_a), .ld_shamt(shamt), .ld_wr_rd(i_wr_rd), .ld_tag(i_tag),
    .busy(busy), .done(done), .y(s_y), .wr_rd(s_wr), .tag(s_tag)
  );
  assign v0 = done | (accept & ~start);
  assign y0 = done ? s_y : y_comb;
  assign wr0 = done ? s_wr : i_wr_rd;
  assign tag0 = done ? s_tag : i_tag;
`else
  logic [XLEN-1:0] sra;
  assign sra = $signed(i_a) >>> shamt;
  assign sh_y = op == ALU_SLL ? i_a << shamt : op == ALU_SRL ? i_a >> shamt : sra;
  assign busy = 1'b0;
  assign v0 = accept;
  assign y0 = y_comb;
  assign wr0 = i_wr_rd;
  assign tag0 = i_tag;
`endif
  for (genvar s = 0; s < STAGES; s++) begin : g_st
    logic v, wr, v_in, wr_in;
    logic [XLEN-1:0] y, y_in;
    logic [TAG_W-1:0] tag, tag_in;
    if (s == 0) begin : g_head
      assign {v_in, wr_in, y_in, tag_in} = {v0, wr0, y0, tag0};
    end else begin : g_link
      assign {v_in, wr_in, y_in, tag_in} = {g_st[s-1].v, g_st[s-1].wr, g_st[s-1].y, g_st[s-1].tag};
    end
    always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
        v <= 1'b0;
        wr <= 1'b0;
        y <= '0;
        tag <= '0;
      end else if (i_flush) v <= 1'b0;
      else if (!i_stall) begin
        v <= v_in;
        wr <= wr_in;
        y <= y_in;
        tag <= tag_in;
      end
  end
  assign o_ce = g_st[STAGES-1].v;
  assign o_y = g_st[STAGES-1].y;
  assign o_tag = g_st[STAGES-1].tag;
  assign o_wr_rd = o_ce & g_st[STAGES-1].wr;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_flush <= 1'b0;
    else o_flush <= i_flush;
endmodule

// File: tb/tb_rv32i_alu_pipe.sv
// tb_rv32i_alu_pipe: scoreboard bench for rv32i_alu_pipe (32-bit/2-stage and 64-bit/3-stage instances).
module tb_rv32i_alu_pipe;
  import rv32i_alu_pkg::*;
  localparam int ST = 2;
`ifdef ALU_SERIAL_SHIFT_EN
  localparam bit SER = 1'b1;
`else
  localparam bit SER = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic ce = 0, wr = 0, stall = 0, flush = 0;
  logic [3:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic [36:0] tag = '0;
  logic oce, owr, ostall, oflush;
  logic [31:0] oy;
  logic [36:0] otag;
  logic h_ce = 0, h_wr = 1, h_stall = 0, h_flush = 0;
  logic [3:0] h_op = '0;
  logic [63:0] h_a = '0, h_b = '0;
  logic [36:0] h_tag = '0;
  logic h_oce, h_owr, h_ostall, h_oflush;
  logic [63:0] h_oy;
  logic [36:0] h_otag;
  rv32i_alu_pipe #(.XLEN(32), .STAGES(ST)) dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_op(op), .i_a(a), .i_b(b), .i_wr_rd(wr), .i_tag(tag),
    .i_stall(stall), .i_flush(flush), .o_ce(oce), .o_y(oy), .o_wr_rd(owr), .o_tag(otag),
    .o_stall(ostall), .o_flush(oflush)
  );
  rv32i_alu_pipe #(.XLEN(64), .STAGES(3)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_ce(h_ce), .i_op(h_op), .i_a(h_a), .i_b(h_b), .i_wr_rd(h_wr),
    .i_tag(h_tag), .i_stall(h_stall), .i_flush(h_flush), .o_ce(h_oce), .o_y(h_oy),
    .o_wr_rd(h_owr), .o_tag(h_otag), .o_stall(h_ostall), .o_flush(h_oflush)
  );
  int errs = 0, checks = 0, ecyc = 0;
  typedef struct {logic [31:0] y; logic [36:0] tag; logic wr; int due;} exp_t;
  exp_t q[$];
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [4:0] s;
    logic lt;
    s = y[4:0];
    lt = (x[31] != y[31]) ? x[31] : (x < y);
    case (o)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return {31'b0, lt};
      4'd6: return {31'b0, x < y};
      4'd7: return x << s;
      4'd8: return x >> s;
      4'd9: return (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      4'd10: return {31'b0, x == y};
      4'd11: return {31'b0, x != y};
      4'd12: return {31'b0, !lt};
      4'd13: return {31'b0, !(x < y)};
      default: return 32'h0;
    endcase
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op_go(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic w, input logic [36:0] t, input bit push);
    int extra;
    ce = 0;
    for (int i = 0; i < 40 && ostall; i++) tick();
    extra = (SER && o inside {4'd7, 4'd8, 4'd9} && y[4:0] != 0) ? (int'(y[4:0]) + 3) / 4 : 0;
    op = o; a = x; b = y; wr = w; tag = t; ce = 1;
    if (push) q.push_back('{model(o, x, y), t, w, ecyc + ST + extra});
    tick();
    ce = 0;
  endtask
  always @(posedge clk) if (!stall) ecyc++;
  always @(negedge clk)
    if (!rst && oce && !stall) begin
      exp_t e;
      if (q.size() == 0) chk("unexpected_o_ce", oce, 0);
      else begin
        e = q.pop_front();
        chk("o_y", oy, e.y);
        chk("o_tag", otag, e.tag);
        chk("o_wr_rd", owr, e.wr);
        chk("latency", ecyc, e.due);
      end
    end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (2) tick();
    chk("rst_o_ce", oce, 0);
    chk("rst_o_y", oy, 0);
    chk("rst_o_tag", otag, 0);
    chk("rst_o_wr_rd", owr, 0);
    chk("rst_o_stall", ostall, 0);
    chk("rst_o_flush", oflush, 0);
    chk("rst_x64_o_ce", h_oce, 0);
    rst = 0;
    tick();
    op_go(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1, 37'h01, 1);
    op_go(ALU_SUB, 32'h0, 32'h1, 1, 37'h02, 1);
    op_go(ALU_SLT, 32'h8000_0000, 32'h1, 1, 37'h03, 1);
    op_go(ALU_SLTU, 32'h8000_0000, 32'h1, 0, 37'h04, 1);
    op_go(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 37'h05, 1);
    op_go(ALU_OR, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 37'h06, 1);
    op_go(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 37'h07, 1);
    op_go(ALU_EQ, 32'h1234_5678, 32'h1234_5678, 1, 37'h08, 1);
    op_go(ALU_NE, 32'h1234_5678, 32'h1234_5678, 1, 37'h09, 1);
    op_go(ALU_GE, 32'hFFFF_FFFF, 32'h1, 1, 37'h0A, 1);
    op_go(ALU_GEU, 32'hFFFF_FFFF, 32'h1, 1, 37'h0B, 1);
    op_go(ALU_SRA, 32'h8000_0000, 32'd31, 1, 37'h0C, 1);
    op_go(ALU_SLL, 32'h3, 32'h21, 1, 37'h0D, 1);
    op_go(ALU_SRL, 32'h8765_4321, 32'h0, 1, 37'h0E, 1);
    op_go(4'hE, 32'h1111_1111, 32'h2222_2222, 1, 37'h1F_0000_000F, 1);
    repeat (30) tick();
    chk("drain_basic", q.size(), 0);
    op_go(ALU_SRL, 32'hF000_0000, 32'd13, 1, 37'h10, 1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      n += int'(ostall);
      tick();
    end
    chk("shift_busy_cycles", n, SER ? 4 : 0);
    repeat (10) tick();
    chk("drain_shift", q.size(), 0);
    op_go(ALU_ADD, 32'd10, 32'd20, 1, 37'h20, 0);
    op_go(ALU_XOR, 32'hFF, 32'h0F, 1, 37'h21, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_o_ce", oce, 1);
      chk("stall_o_y", oy, 32'd30);
      chk("stall_o_tag", otag, 37'h20);
      tick();
    end
    flush = 1;
    tick();
    flush = 0;
    chk("flush_o_ce", oce, 0);
    chk("flush_o_flush", oflush, 1);
    stall = 0;
    tick();
    chk("flush_stage0_killed", oce, 0);
    chk("flush_o_flush_drop", oflush, 0);
    op = ALU_ADD; a = 32'd1; b = 32'd1; ce = 1; flush = 1;
    tick();
    ce = 0; flush = 0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_beats_accept", oce, 0);
      tick();
    end
    op_go(ALU_SRL, 32'hFFFF_0000, 32'd31, 1, 37'h30, 0);
    flush = 1;
    tick();
    flush = 0;
    chk("flush_shift_o_stall", ostall, 0);
    repeat (20) tick();
    chk("flush_shift_no_o_ce", oce, 0);
    op_go(ALU_ADD, 32'd1, 32'd2, 1, 37'h40, 1);
    op_go(ALU_ADD, 32'd3, 32'd4, 1, 37'h41, 1);
    op_go(ALU_ADD, 32'd5, 32'd6, 1, 37'h42, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_o_ce", oce, 0);
    chk("async_rst_o_y", oy, 0);
    chk("async_rst_o_stall", ostall, 0);
    q.delete();
    tick();
    rst = 0;
    tick();
    h_op = ALU_SLL; h_a = 64'h1; h_b = 64'd63; h_tag = 37'h1F_0000_ABCD; h_ce = 1;
    tick();
    h_ce = 0;
    n = 1;
    while (!h_oce && n < 60) begin
      tick();
      n++;
    end
    chk("x64_latency", n, SER ? 19 : 3);
    chk("x64_o_y", h_oy, 64'h8000_0000_0000_0000);
    chk("x64_o_tag", h_otag, 37'h1F_0000_ABCD);
    chk("x64_o_wr_rd", h_owr, 1);
    repeat (3) tick();
    chk("drain_final", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
